shufflenet_stage_scheduler: RTL
===============================

Name: shufflenet_stage_scheduler

Overview:
Sequencing controller for the ShuffleNet datapath and its feature-map memory control.
- Waits for a complete MFSC feature map, then walks every network stage, every kernel within a stage and every step within a kernel.
- Issues the kernel-read, feature-map-read and feature-map-write enables, and ping-pongs the BRAM bank select at each stage boundary.
- Flags the classification result when the final stage drains.
- Per-stage loop limits come from an external configuration ROM addressed by the current stage.

Parameters:
- NUM_STAGES, 40: number of network stages; the last stage index is NUM_STAGES-1.
- PIPE_LAT, 3: cycles from a feature-map read enable to the matching write enable (datapath latency, must be at least 1).
- STAGE_W, 6: stage counter width.
- CNT_W, 7: kernel and step counter width.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- feature_map_ready, input, 1: MFSC feature map complete; level signal.
- cfg_kernel_last, input, CNT_W: last kernel index of the current stage (combinational from the ROM, indexed by stage_count).
- cfg_step_last, input, CNT_W: last step index per kernel of the current stage.
- stage_count, output, STAGE_W: current stage.
- stage_count_next, output, STAGE_W: value stage_count takes at the next clock edge.
- kernel_count, output, CNT_W: current kernel.
- kernel_count_next, output, CNT_W: next-edge value of kernel_count.
- step_count, output, CNT_W: current step.
- read_kernel_enable, output, 1: load weights for kernel_count.
- read_featuremap_enable, output, 1: read one input word.
- write_featuremap_enable, output, 1: write one output word.
- select_bramA, output, 1: bank select; 1 means bank A is the source.
- shuffleNet_Result_Ready, output, 1: one-cycle pulse when the inference is complete.
- busy, output, 1: high from leaving WAIT_MFSC until the result pulse.

Behaviour:
- Reset values: all counters 0, select_bramA=1, every enable and pulse 0, busy 0, state WAIT_MFSC. Reset mid-operation aborts immediately; the pipeline shift register is cleared and no write is issued after reset.
- WAIT_MFSC: feature_map_ready is sampled only in this state. When it is 1, go to LOAD and set busy.
- LOAD: read_kernel_enable=1 for exactly one cycle, then go to RUN with step_count=0.
- RUN:
  - read_featuremap_enable=1 every cycle; step_count increments each cycle.
  - At step_count==cfg_step_last, go to DRAIN.
  - step_last=0 gives exactly one read.
- DRAIN: wait PIPE_LAT cycles until the pipeline is empty, then choose one branch:
  - kernel_count<cfg_kernel_last: kernel_count+1, go to LOAD.
  - otherwise, if stage_count<NUM_STAGES-1: stage_count+1, kernel_count=0, toggle select_bramA, go to LOAD.
  - otherwise: go to DONE.
- DONE: shuffleNet_Result_Ready=1 for one cycle. Then reset stage_count, kernel_count and step_count to 0, set select_bramA=1, clear busy, go to WAIT_MFSC.
- write_featuremap_enable is read_featuremap_enable delayed by exactly PIPE_LAT cycles through a shift register. The total number of writes always equals the total number of reads.
- *_next outputs are the combinational D inputs of the counter registers, so they match the registered value one cycle later.
- Counters never wrap. Config values are sampled only at the LOAD and DRAIN decision points; changing them mid-RUN takes effect at the next decision.
- feature_map_ready held high through DONE starts a new inference one cycle after DONE.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined: adds output perf_cycles[31:0].
  - Counts clk cycles while busy; cleared when WAIT_MFSC is left.
  - Holds its final value until the next start.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package shufflenet_sched_pkg holds:
  - the state enum (WAIT_MFSC, LOAD, RUN, DRAIN, DONE);
  - the STAGE_W and CNT_W defaults;
  - the NUM_STAGES constant shared with the config ROM and memory control.
- One sub-module, sched_delay_line: a PIPE_LAT-deep 1-bit shift register with asynchronous clear that produces the write enable.

Test Plan:
1. NUM_STAGES=2, both stages kernel_last=1 and step_last=3, PIPE_LAT=3; pulse feature_map_ready
   -> 4 read_kernel_enable pulses and 16 reads/16 writes;
   -> each write 3 cycles after its read;
   -> select_bramA goes 1→0 at the stage change and returns to 1 after the result pulse.
2. kernel_last=0, step_last=0 -> per stage exactly 1 kernel load and 1 read, then 1 write 3 cycles later.
3. Hold feature_map_ready=1 continuously -> after DONE, next LOAD begins one cycle after the result pulse; busy low for only that one cycle.
4. Assert rst_n=0 mid-RUN (stage 1, kernel 1, step 2) -> all outputs return to reset values at once; no write_featuremap_enable pulses afterward.
5. Check stage_count_next and kernel_count_next against stage_count and kernel_count delayed one cycle, across every boundary of test 1 -> always equal.
6. With SCHED_PERF_CNT_EN defined and the config of test 1 -> perf_cycles equals the cycle count measured from busy rising to busy falling.

Source files
------------

// File: rtl/shufflenet_sched_pkg.sv
// Shared types and constants for the ShuffleNet stage scheduler,
// its config ROM and the feature-map memory control.
package shufflenet_sched_pkg;

  localparam int NUM_STAGES = 40;
  localparam int STAGE_W    = 6;
  localparam int CNT_W      = 7;

  typedef enum logic [2:0] {
    WAIT_MFSC,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/shufflenet_sched_if.sv
// Scheduler bundle: MFSC start, per-stage config from the ROM,
// counters, memory enables, bank select and result/busy status.
// SCHED_PERF_CNT_EN adds perf_cycles (busy cycle count).
interface shufflenet_sched_if #(
  parameter int STAGE_W = shufflenet_sched_pkg::STAGE_W,
  parameter int CNT_W   = shufflenet_sched_pkg::CNT_W
);

  logic               feature_map_ready;
  logic [CNT_W-1:0]   cfg_kernel_last;
  logic [CNT_W-1:0]   cfg_step_last;
  logic [STAGE_W-1:0] stage_count;
  logic [STAGE_W-1:0] stage_count_next;
  logic [CNT_W-1:0]   kernel_count;
  logic [CNT_W-1:0]   kernel_count_next;
  logic [CNT_W-1:0]   step_count;
  logic               read_kernel_enable;
  logic               read_featuremap_enable;
  logic               write_featuremap_enable;
  logic               select_bramA;
  logic               shuffleNet_Result_Ready;
  logic               busy;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]        perf_cycles;
`endif

  modport master (
    input  feature_map_ready,
    input  cfg_kernel_last,
    input  cfg_step_last,
    output stage_count,
    output stage_count_next,
    output kernel_count,
    output kernel_count_next,
    output step_count,
    output read_kernel_enable,
    output read_featuremap_enable,
    output write_featuremap_enable,
    output select_bramA,
    output shuffleNet_Result_Ready,
`ifdef SCHED_PERF_CNT_EN
    output perf_cycles,
`endif
    output busy
  );

  modport slave (
    output feature_map_ready,
    output cfg_kernel_last,
    output cfg_step_last,
    input  stage_count,
    input  stage_count_next,
    input  kernel_count,
    input  kernel_count_next,
    input  step_count,
    input  read_kernel_enable,
    input  read_featuremap_enable,
    input  write_featuremap_enable,
    input  select_bramA,
    input  shuffleNet_Result_Ready,
`ifdef SCHED_PERF_CNT_EN
    input  perf_cycles,
`endif
    input  busy
  );

endinterface

// File: rtl/sched_delay_line.sv
// DEPTH-deep 1-bit shift register with async clear.
// Ports: clk, rst_n, i_d (read enable), o_q (delayed write enable).
module sched_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sr;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= i_d;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sr <= '0;
        else        r_sr <= {r_sr[DEPTH-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/shufflenet_stage_scheduler.sv
// Stage/kernel/step sequencer for the ShuffleNet datapath.
// Ports: clk, rst_n, bus (shufflenet_sched_if.master).
// SCHED_PERF_CNT_EN adds the bus.perf_cycles busy-cycle counter.
module shufflenet_stage_scheduler #(
  parameter int NUM_STAGES = shufflenet_sched_pkg::NUM_STAGES,
  parameter int PIPE_LAT   = 3,
  parameter int STAGE_W    = shufflenet_sched_pkg::STAGE_W,
  parameter int CNT_W      = shufflenet_sched_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  shufflenet_sched_if.master  bus
);

  import shufflenet_sched_pkg::*;

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  sched_state_t       r_state, w_state_nxt;
  logic [STAGE_W-1:0] r_stage, w_stage_nxt;
  logic [CNT_W-1:0]   r_kernel, w_kernel_nxt;
  logic [CNT_W-1:0]   r_step, w_step_nxt;
  logic [CNT_W-1:0]   r_step_last, w_step_last_nxt;
  logic [DW-1:0]      r_drain, w_drain_nxt;
  logic               r_sel, w_sel_nxt;
  logic               w_rk, w_rd, w_wr, w_done, w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_MFSC;
      r_stage     <= '0;
      r_kernel    <= '0;
      r_step      <= '0;
      r_step_last <= '0;
      r_drain     <= '0;
      r_sel       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_kernel    <= w_kernel_nxt;
      r_step      <= w_step_nxt;
      r_step_last <= w_step_last_nxt;
      r_drain     <= w_drain_nxt;
      r_sel       <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stage_nxt     = r_stage;
    w_kernel_nxt    = r_kernel;
    w_step_nxt      = r_step;
    w_step_last_nxt = r_step_last;
    w_drain_nxt     = r_drain;
    w_sel_nxt       = r_sel;
    w_rk            = 1'b0;
    w_rd            = 1'b0;
    w_done          = 1'b0;
    w_busy          = 1'b1;
    unique case (r_state)
      WAIT_MFSC: begin
        w_busy = 1'b0;
        if (bus.feature_map_ready) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_rk            = 1'b1;
        // Step limit is latched here so mid-RUN ROM changes wait
        // for the next kernel.
        w_step_last_nxt = bus.cfg_step_last;
        w_step_nxt      = '0;
        w_state_nxt     = RUN;
      end
      RUN: begin
        w_rd = 1'b1;
        if (r_step == r_step_last) begin
          w_drain_nxt = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_step_nxt = r_step + 1'b1;
        end
      end
      DRAIN: begin
        if (r_drain == DRAIN_LAST) begin
          if (r_kernel < bus.cfg_kernel_last) begin
            w_kernel_nxt = r_kernel + 1'b1;
            w_step_nxt   = '0;
            w_state_nxt  = LOAD;
          end else if (r_stage < STAGE_LAST) begin
            w_stage_nxt  = r_stage + 1'b1;
            w_kernel_nxt = '0;
            w_step_nxt   = '0;
            w_sel_nxt    = ~r_sel;
            w_state_nxt  = LOAD;
          end else begin
            w_state_nxt  = DONE;
          end
        end else begin
          w_drain_nxt = r_drain + 1'b1;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_stage_nxt  = '0;
        w_kernel_nxt = '0;
        w_step_nxt   = '0;
        w_sel_nxt    = 1'b1;
        w_state_nxt  = WAIT_MFSC;
      end
      default: begin
        w_state_nxt = WAIT_MFSC;
      end
    endcase
  end

  sched_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_rd),
    .o_q   (w_wr)
  );

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (r_state == WAIT_MFSC && bus.feature_map_ready) begin
      r_perf <= '0;
    end else if (w_busy && r_perf != 32'hFFFF_FFFF) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf;
`endif

  assign bus.stage_count             = r_stage;
  assign bus.stage_count_next        = w_stage_nxt;
  assign bus.kernel_count            = r_kernel;
  assign bus.kernel_count_next       = w_kernel_nxt;
  assign bus.step_count              = r_step;
  assign bus.read_kernel_enable      = w_rk;
  assign bus.read_featuremap_enable  = w_rd;
  assign bus.write_featuremap_enable = w_wr;
  assign bus.select_bramA            = r_sel;
  assign bus.shuffleNet_Result_Ready = w_done;
  assign bus.busy                    = w_busy;

endmodule
